// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver/transmitter FSM encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Mid-bit offset used to centre the start-bit sample.
  function automatic logic [15:0] half_div(input logic [15:0] div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO holding received bytes.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot a simultaneous push needs, so full+pop still accepts.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, bit-timing FSM, receive FIFO and sticky error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_DIV    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        rx_en,
  input  logic [15:0] clk_div,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        overrun,
  input  logic        err_clr,
  output logic        intr
);

  localparam int BW = $clog2(DATA_BITS);

  logic                 rx_s1_q, rxs_q, rxs_prev_q;
  uart_state_e          state_q, state_d;
  logic [15:0]          div_q, div_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 intr_q, intr_d;
  logic                 push, ferr_set, ovr_set;
  logic                 fifo_full, fifo_empty;
  logic                 tick_half, tick_full, fall, div_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_s1_q    <= rx;
      rxs_q      <= rx_s1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign fall      = rxs_prev_q & ~rxs_q;
  // An illegal divisor keeps the receiver idle instead of running a degenerate frame.
  assign div_ok    = (clk_div >= 16'(MIN_DIV));
  assign tick_half = (cnt_q == half_div(div_q) - 16'd1);
  assign tick_full = (cnt_q == div_q - 16'd1);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_en && fall && div_ok) begin
          state_d   = ST_START;
          div_d     = clk_div;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick_half) begin
          cnt_d   = '0;
          state_d = rxs_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (tick_full) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_BITS-1)) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (tick_full) begin
          cnt_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_BREAK: begin
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling aborts the frame outright: no byte, no flag.
    if (!rx_en) begin
      state_d  = ST_IDLE;
      push     = 1'b0;
      ferr_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (shift_q),
    .pop   (rd_en),
    .head  (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  assign ovr_set  = push & fifo_full & ~(rd_en & ~fifo_empty);

  // Set beats clear when both land on the same edge.
  always_comb begin
    frame_err_d = ferr_set | (frame_err_q & ~err_clr);
    overrun_d   = ovr_set | (overrun_q & ~err_clr);
    intr_d      = rx_valid | frame_err_q | overrun_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      intr_q      <= intr_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign intr      = intr_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter MIN_DIV, default 4, smallest legal clk_div value.
REQ-003 SHALL have port clk, input, 1, the only clock.
REQ-004 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have port rx, input, 1, serial line (idle high, 8N1, LSB first), asynchronous to clk.
REQ-006 SHALL have port rx_en, input, 1, receiver enable.
REQ-007 SHALL have port clk_div, input, 16, clk cycles per bit.
REQ-008 SHALL have port rd_en, input, 1, pop FIFO head.
REQ-009 SHALL have port rd_data, output, 8, FIFO head (first-word fall-through).
REQ-010 SHALL have port rx_valid, output, 1, FIFO non-empty.
REQ-011 SHALL have port frame_err, output, 1, sticky stop-bit error.
REQ-012 SHALL have port overrun, output, 1, sticky byte-dropped flag.
REQ-013 SHALL have port err_clr, input, 1, clears both sticky flags.
REQ-014 SHALL have port intr, output, 1, level interrupt = rx_valid | frame_err | overrun, registered.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value (rxs).
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-017 IDLE: a 1->0 transition of rxs with rx_en=1 SHALL enter START, latch clk_div into div_q, and clear the bit counter.
REQ-018 START: at div_q>>1 cycles after entry, rxs SHALL be sampled; 0 -> DATA, 1 -> IDLE (glitch rejected, no flag).
REQ-019 DATA: SHALL sample rxs every div_q cycles, shift in LSB first, and go to STOP after the 8th sample.
REQ-020 STOP: SHALL sample after div_q cycles; 1 -> push byte, go to IDLE; 0 -> discard byte, set frame_err, go to BREAK.
REQ-021 BREAK: SHALL wait until rxs=1, then go to IDLE.
REQ-022 A pushed byte SHALL appear on rd_data with rx_valid=1 on the cycle after the stop sample.
REQ-023 rd_en with rx_valid=1 SHALL pop the head on that edge; rd_en with rx_valid=0 SHALL be ignored.
REQ-024 A push into a full FIFO without a same-cycle pop SHALL drop the byte, set overrun, and leave the contents unchanged.
REQ-025 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full (no overrun).
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-027 err_clr SHALL clear frame_err and overrun on the next edge; a same-cycle set SHALL win over the clear.
REQ-028 rx_en=0 SHALL force IDLE next cycle, aborting any frame without flags; FIFO contents and flags SHALL be retained.
REQ-029 Changes to clk_div mid-frame SHALL NOT affect the current frame.
REQ-030 Behaviour for clk_div < MIN_DIV is undefined and need not be checked.

Reset
REQ-031 On rst_n=0: state=IDLE, FIFO empty, rd_data=0x00, rx_valid=0, frame_err=0, overrun=0, intr=0, synchronizer flops=1.
REQ-032 Reset asserted mid-frame SHALL discard the partial byte; after release, the receiver SHALL wait for a new falling edge.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum and the constant DATA_BITS=8; the package is shared with the transmitter.
REQ-034 The FIFO SHALL be the sub-module uart_rx_fifo (sync FIFO with push, pop, full, empty, and head outputs).

Verification
REQ-035 Run clk_div=16 and send 0x0F, 0x1E, 0x3C back-to-back. Check three pops return 0x0F, 0x1E, 0x3C in order; intr is high while non-empty; no flags.
REQ-036 Send 0x55 with stop bit=0, then rx held low 40 cycles, then 0xA5. Check frame_err=1, 0x55 not stored, 0xA5 received; err_clr then drops frame_err.
REQ-037 FIFO_DEPTH=4, five bytes 0x01..0x05, no reads. Check overrun=1 and the FIFO holds 0x01..0x04. Repeat with rd_en pulsed on the 5th push cycle: overrun=0 and 0x05 stored.
REQ-038 Drive a 4-cycle low glitch on rx with clk_div=16. Check the FSM returns to IDLE, nothing is pushed, and no flags are set.
REQ-039 Assert rst_n low during DATA bit 4 of 0x3C, release, then send 0x0F. Check only 0x0F is received.
REQ-040 Drop rx_en mid-frame while 2 bytes are queued. Check the FSM goes to IDLE, both bytes are still readable, and no flags are set.
